// File: rtl/debounce_scheduler_pkg.sv
// Shared defaults and helpers for the button debounce scheduler.
// Imported by the lane filter and the top-level arbiter.
package debounce_scheduler_pkg;

  localparam int unsigned DEF_N_BTN    = 4;
  localparam int unsigned DEF_DEPTH    = 3;
  localparam int unsigned DEF_TICK_DIV = 50000;
  localparam int unsigned DEF_CW       = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_scheduler_lane.sv
// One button lane: 2-FF synchronizer, tick-enabled history filter,
// debounced level and a one-cycle rise strobe on the 0->1 level change.
module debounce_lane
  import debounce_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise
);

  logic             s1;
  logic             s2;
  logic [DEPTH-1:0] hist;
  logic [DEPTH-1:0] hist_n;

  assign hist_n = {hist[DEPTH-2:0], s2};
  assign rise   = tick & ~level & (&hist_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist  <= '0;
      level <= 1'b0;
    end else if (tick) begin
      hist <= hist_n;
      if (&hist_n)
        level <= 1'b1;
      else if (~|hist_n)
        level <= 1'b0;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces N_BTN buttons on a shared sample tick, queues presses and
// offers them one at a time over valid/ready with round-robin order.
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int unsigned N_BTN    = DEF_N_BTN,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BTN-1:0]          btn_in,
  output logic [N_BTN-1:0]          btn_level,
  output logic                      evt_valid,
  output logic [clog2(N_BTN)-1:0]   evt_id,
  input  logic                      evt_ready,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int unsigned IW = clog2(N_BTN);

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] cand;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick;
  logic             found;
  logic             hs;
  logic             load;
  logic             ovf_set;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    debounce_lane #(
      .DEPTH (DEPTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .din   (btn_in[g]),
      .level (btn_level[g]),
      .rise  (rise[g])
    );
  end

  assign hs   = evt_valid & evt_ready;
  assign load = ~evt_valid | hs;

  always_comb begin
    clr = '0;
    if (hs)
      clr[evt_id] = 1'b1;
  end

  // A new press on the lane being accepted survives as a fresh pending.
  assign ovf_set = |(rise & pending & ~clr);
  assign cand    = pending & ~clr;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < int'(N_BTN); k++) begin
      if (!found && cand[(int'(rr_ptr) + k) % int'(N_BTN)]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_ptr) + k) % int'(N_BTN));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= cand | rise;
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        evt_valid <= found;
        if (found)
          evt_id <= pick;
      end
      if (hs)
        rr_ptr <= (evt_id == IW'(N_BTN - 1)) ? '0 : evt_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_BTN=4, DEPTH=3, TICK_DIV=4.
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready = 1'b0;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  debounce_scheduler #(
    .N_BTN    (4),
    .DEPTH    (3),
    .TICK_DIV (4),
    .CW       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_lvl(input int ln, input logic v);
    int b;
    b = 0;
    while (btn_level[ln] !== v && b < 80) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic wait_valid();
    int b;
    b = 0;
    while (evt_valid !== 1'b1 && b < 80) begin
      @(negedge clk);
      b++;
    end
  endtask

  logic seen;
  logic stable;

  initial begin
    // 1: reset, then idle
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_id", evt_id, 0);
    clks(3);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (evt_valid || btn_level != 0 || overflow) seen = 1'b1;
    end
    chk("idle_quiet", seen, 0);

    // 2: single press with ready high
    evt_ready = 1'b1;
    btn_in[2] = 1'b1;
    wait_lvl(2, 1'b1);
    chk("t2_lvl", btn_level, 4'b0100);
    chk("t2_valid_pre", evt_valid, 0);
    clks(1);
    chk("t2_valid", evt_valid, 1);
    chk("t2_id", evt_id, 2);
    clks(1);
    chk("t2_valid_off", evt_valid, 0);
    btn_in[2] = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid) seen = 1'b1;
    end
    chk("t2_release_lvl", btn_level[2], 0);
    chk("t2_no_fall_evt", seen, 0);

    // 3: short glitch is filtered
    btn_in[1] = 1'b1;
    clks(5);
    btn_in[1] = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid || btn_level[1]) seen = 1'b1;
    end
    chk("t3_glitch", seen, 0);

    // 4: simultaneous presses, round-robin resumes after lane 2
    evt_ready = 1'b0;
    btn_in = 4'b1001;
    wait_valid();
    chk("t4_valid", evt_valid, 1);
    chk("t4_id_first", evt_id, 3);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!evt_valid || evt_id != 2'd3) stable = 1'b0;
    end
    chk("t4_hold", stable, 1);
    evt_ready = 1'b1;
    clks(1);
    evt_ready = 1'b0;
    chk("t4_valid2", evt_valid, 1);
    chk("t4_id_second", evt_id, 0);
    evt_ready = 1'b1;
    clks(1);
    evt_ready = 1'b0;
    chk("t4_drained", evt_valid, 0);
    btn_in = 4'b0000;
    wait_lvl(0, 1'b0);
    wait_lvl(3, 1'b0);
    chk("t4_release", btn_level, 0);

    // 5: second press while pending -> overflow
    btn_in[1] = 1'b1;
    wait_lvl(1, 1'b1);
    clks(1);
    chk("t5_valid", evt_valid, 1);
    chk("t5_id", evt_id, 1);
    chk("t5_ovf_pre", overflow, 0);
    btn_in[1] = 1'b0;
    wait_lvl(1, 1'b0);
    btn_in[1] = 1'b1;
    wait_lvl(1, 1'b1);
    chk("t5_ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    clks(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", overflow, 0);
    chk("t5_id_hold", evt_id, 1);
    evt_ready = 1'b1;
    clks(1);
    evt_ready = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      if (evt_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("t5_single_evt", seen, 0);
    btn_in[1] = 1'b0;
    wait_lvl(1, 1'b0);
    chk("t5_release", btn_level[1], 0);

    // 6: async reset while an event is offered
    btn_in[2] = 1'b1;
    wait_lvl(2, 1'b1);
    clks(1);
    chk("t6_valid", evt_valid, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_level", btn_level, 0);
    chk("t6_rst_ovf", overflow, 0);
    @(negedge clk);
    btn_in = 4'b0000;
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (evt_valid || btn_level != 0) seen = 1'b1;
    end
    chk("t6_no_stale", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
